// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle restoring signed integer divider, one quotient bit per clock
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FINISH
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] qreg_q, qreg_d;
    logic [WIDTH-1:0] dabs_q, dabs_d;
    logic [CW-1:0]    count_q, count_d;
    logic             sign_quo_q, sign_quo_d;
    logic             sign_rem_q, sign_rem_d;
    logic             dbz_pend_q, dbz_pend_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] dividend_abs;
    logic [WIDTH-1:0] divisor_abs;
    logic [WIDTH:0]   acc_shift;
    logic [WIDTH:0]   trial;

    // Unsigned magnitudes (|MIN_INT| stays exact) and the trial subtraction of the current step
    always_comb begin
        dividend_abs = dividend[WIDTH-1] ? -dividend : dividend;
        divisor_abs  = divisor[WIDTH-1]  ? -divisor  : divisor;
        acc_shift    = {acc_q, qreg_q[WIDTH-1]};
        trial        = acc_shift - {1'b0, dabs_q};
    end

    // Next-state and datapath control. CALC spends one extra cycle observing count==0 before
    // FINISH; a divide-by-zero enters CALC with count already 0, so both paths share that tail.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        qreg_d      = qreg_q;
        dabs_d      = dabs_q;
        count_d     = count_q;
        sign_quo_d  = sign_quo_q;
        sign_rem_d  = sign_rem_q;
        dbz_pend_d  = dbz_pend_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        dbz_d       = dbz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    busy_d     = 1'b1;
                    state_d    = CALC;
                    acc_d      = '0;
                    sign_quo_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                    sign_rem_d = dividend[WIDTH-1];
                    if (divisor == '0) begin
                        qreg_d     = dividend;
                        dabs_d     = '0;
                        count_d    = '0;
                        dbz_pend_d = 1'b1;
                    end else begin
                        qreg_d     = dividend_abs;
                        dabs_d     = divisor_abs;
                        count_d    = CW'(WIDTH);
                        dbz_pend_d = 1'b0;
                    end
                end
            end
            CALC: begin
                if (count_q == '0) begin
                    state_d = FINISH;
                end else begin
                    if (!trial[WIDTH]) begin
                        acc_d  = trial[WIDTH-1:0];
                        qreg_d = {qreg_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d  = acc_shift[WIDTH-1:0];
                        qreg_d = {qreg_q[WIDTH-2:0], 1'b0};
                    end
                    count_d = count_q - CW'(1);
                end
            end
            FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
                if (dbz_pend_q) begin
                    quotient_d  = '1;
                    remainder_d = qreg_q;
                    dbz_d       = 1'b1;
                end else begin
                    quotient_d  = sign_quo_q ? -qreg_q : qreg_q;
                    remainder_d = sign_rem_q ? -acc_q : acc_q;
                    dbz_d       = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any in-flight operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            qreg_q      <= '0;
            dabs_q      <= '0;
            count_q     <= '0;
            sign_quo_q  <= 1'b0;
            sign_rem_q  <= 1'b0;
            dbz_pend_q  <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            qreg_q      <= qreg_d;
            dabs_q      <= dabs_d;
            count_q     <= count_d;
            sign_quo_q  <= sign_quo_d;
            sign_rem_q  <= sign_rem_d;
            dbz_pend_q  <= dbz_pend_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            dbz_q       <= dbz_d;
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - directed self-checking bench for seq_divider
module tb_seq_divider;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    int vectors;
    int miscompares;

    seq_divider #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive operands with start, step past the sampling edge E0, drop start
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Count edges after E0 until done; busy must be high before done and low with it
    task automatic wait_done(output int lat, output int busy_bad);
        lat      = 0;
        busy_bad = 0;
        while (done !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            if (done !== 1'b1 && busy !== 1'b1) busy_bad++;
        end
        if (done === 1'b1 && busy !== 1'b0) busy_bad++;
    endtask

    task automatic test_reset;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (quotient !== 32'h0) begin miscompares++; $display("FAIL reset_quotient got %h want 00000000", quotient); end
        vectors++; if (remainder !== 32'h0) begin miscompares++; $display("FAIL reset_remainder got %h want 00000000", remainder); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
        vectors++; if (div_by_zero !== 1'b0) begin miscompares++; $display("FAIL reset_dbz got %b want 0", div_by_zero); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic;
        int lat, bb;
        start_op(32'd100, 32'd7);
        wait_done(lat, bb);
        vectors++; if (lat !== 34) begin miscompares++; $display("FAIL basic_latency got %0d want 34", lat); end
        vectors++; if (bb !== 0) begin miscompares++; $display("FAIL basic_busy bad samples got %0d want 0", bb); end
        vectors++; if (quotient !== 32'd14) begin miscompares++; $display("FAIL basic_quotient got %h want 0000000e", quotient); end
        vectors++; if (remainder !== 32'd2) begin miscompares++; $display("FAIL basic_remainder got %h want 00000002", remainder); end
        vectors++; if (div_by_zero !== 1'b0) begin miscompares++; $display("FAIL basic_dbz got %b want 0", div_by_zero); end
        @(posedge clk);
        #1;
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL basic_done_pulse got %b want 0", done); end
        vectors++; if (quotient !== 32'd14) begin miscompares++; $display("FAIL basic_hold got %h want 0000000e", quotient); end
    endtask

    task automatic test_signs;
        logic [31:0] ta [4];
        logic [31:0] tb [4];
        logic [31:0] tq [4];
        logic [31:0] tr [4];
        int lat, bb;
        ta = '{32'hFFFFFF9C, 32'd100,     32'hFFFFFF9C, 32'd5};
        tb = '{32'd7,        32'hFFFFFFF9, 32'hFFFFFFF9, 32'd3};
        tq = '{32'hFFFFFFF2, 32'hFFFFFFF2, 32'd14,      32'd1};
        tr = '{32'hFFFFFFFE, 32'd2,        32'hFFFFFFFE, 32'd2};
        for (int i = 0; i < 4; i++) begin
            start_op(ta[i], tb[i]);
            wait_done(lat, bb);
            vectors++; if (quotient !== tq[i]) begin miscompares++; $display("FAIL signs_quotient[%0d] got %h want %h", i, quotient, tq[i]); end
            vectors++; if (remainder !== tr[i]) begin miscompares++; $display("FAIL signs_remainder[%0d] got %h want %h", i, remainder, tr[i]); end
            vectors++; if (lat !== 34) begin miscompares++; $display("FAIL signs_latency[%0d] got %0d want 34", i, lat); end
        end
    endtask

    task automatic test_edges;
        logic [31:0] ta [3];
        logic [31:0] tb [3];
        logic [31:0] tq [3];
        logic [31:0] tr [3];
        int lat, bb;
        ta = '{32'h80000000, 32'h7FFFFFFF, 32'd3};
        tb = '{32'hFFFFFFFF, 32'd1,        32'd8};
        tq = '{32'h80000000, 32'h7FFFFFFF, 32'd0};
        tr = '{32'd0,        32'd0,        32'd3};
        for (int i = 0; i < 3; i++) begin
            start_op(ta[i], tb[i]);
            wait_done(lat, bb);
            vectors++; if (quotient !== tq[i]) begin miscompares++; $display("FAIL edge_quotient[%0d] got %h want %h", i, quotient, tq[i]); end
            vectors++; if (remainder !== tr[i]) begin miscompares++; $display("FAIL edge_remainder[%0d] got %h want %h", i, remainder, tr[i]); end
            vectors++; if (div_by_zero !== 1'b0) begin miscompares++; $display("FAIL edge_dbz[%0d] got %b want 0", i, div_by_zero); end
        end
    endtask

    task automatic test_div_by_zero;
        int lat, bb;
        start_op(32'hFFFFFFFC, 32'd0);
        wait_done(lat, bb);
        vectors++; if (lat !== 2) begin miscompares++; $display("FAIL dbz_latency got %0d want 2", lat); end
        vectors++; if (bb !== 0) begin miscompares++; $display("FAIL dbz_busy bad samples got %0d want 0", bb); end
        vectors++; if (quotient !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL dbz_quotient got %h want ffffffff", quotient); end
        vectors++; if (remainder !== 32'hFFFFFFFC) begin miscompares++; $display("FAIL dbz_remainder got %h want fffffffc", remainder); end
        vectors++; if (div_by_zero !== 1'b1) begin miscompares++; $display("FAIL dbz_flag got %b want 1", div_by_zero); end
        start_op(32'd6, 32'd3);
        vectors++; if (div_by_zero !== 1'b1) begin miscompares++; $display("FAIL dbz_flag_hold got %b want 1", div_by_zero); end
        wait_done(lat, bb);
        vectors++; if (div_by_zero !== 1'b0) begin miscompares++; $display("FAIL dbz_clear got %b want 0", div_by_zero); end
        vectors++; if (quotient !== 32'd2) begin miscompares++; $display("FAIL dbz_next_quotient got %h want 00000002", quotient); end
        vectors++; if (remainder !== 32'd0) begin miscompares++; $display("FAIL dbz_next_remainder got %h want 00000000", remainder); end
    endtask

    task automatic test_held_start;
        int lat, bb;
        start    = 1'b1;
        dividend = 32'd100;
        divisor  = 32'd7;
        @(posedge clk);
        #1;
        dividend = 32'd50;
        divisor  = 32'd5;
        wait_done(lat, bb);
        start = 1'b0;
        vectors++; if (lat !== 34) begin miscompares++; $display("FAIL held_latency got %0d want 34", lat); end
        vectors++; if (quotient !== 32'd14) begin miscompares++; $display("FAIL held_quotient got %h want 0000000e", quotient); end
        vectors++; if (remainder !== 32'd2) begin miscompares++; $display("FAIL held_remainder got %h want 00000002", remainder); end
        @(posedge clk);
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL held_idle_busy got %b want 0", busy); end
    endtask

    task automatic test_back_to_back;
        int lat, bb;
        start_op(32'd5, 32'd3);
        wait_done(lat, bb);
        vectors++; if (quotient !== 32'd1) begin miscompares++; $display("FAIL b2b_first_quotient got %h want 00000001", quotient); end
        start_op(32'd20, 32'd6);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b_accept_busy got %b want 1", busy); end
        wait_done(lat, bb);
        vectors++; if (lat !== 34) begin miscompares++; $display("FAIL b2b_latency got %0d want 34", lat); end
        vectors++; if (quotient !== 32'd3) begin miscompares++; $display("FAIL b2b_quotient got %h want 00000003", quotient); end
        vectors++; if (remainder !== 32'd2) begin miscompares++; $display("FAIL b2b_remainder got %h want 00000002", remainder); end
    endtask

    task automatic test_reset_mid;
        int lat, bb, seen;
        start_op(32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL mid_busy_before got %b want 1", busy); end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++; if (quotient !== 32'h0) begin miscompares++; $display("FAIL mid_quotient got %h want 00000000", quotient); end
        vectors++; if (remainder !== 32'h0) begin miscompares++; $display("FAIL mid_remainder got %h want 00000000", remainder); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_busy got %b want 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL mid_done got %b want 0", done); end
        vectors++; if (div_by_zero !== 1'b0) begin miscompares++; $display("FAIL mid_dbz got %b want 0", div_by_zero); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen  = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        vectors++; if (seen !== 0) begin miscompares++; $display("FAIL mid_no_done got %0d active cycles want 0", seen); end
        start_op(32'hFFFFFFF8, 32'hFFFFFFFD);
        wait_done(lat, bb);
        vectors++; if (quotient !== 32'd2) begin miscompares++; $display("FAIL mid_after_quotient got %h want 00000002", quotient); end
        vectors++; if (remainder !== 32'hFFFFFFFE) begin miscompares++; $display("FAIL mid_after_remainder got %h want fffffffe", remainder); end
        vectors++; if (lat !== 34) begin miscompares++; $display("FAIL mid_after_latency got %0d want 34", lat); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset;
        test_basic;
        test_signs;
        test_edges;
        test_div_by_zero;
        test_held_start;
        test_back_to_back;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
